apb_master: RTL

Single-outstanding APB initiator for the APB bridge. It accepts a packed command on a valid/ready interface and decodes one of NSLV slaves from the top address bits. It runs the two-phase APB SETUP/ACCESS transfer, honouring `pready` wait states with an optional timeout, and returns read data and status on a valid/ready response interface.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_master_tmo.sv | 42 ++++
 rtl/apb_master.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared state encoding, command field offsets and default
//               widths for the APB initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Default widths shared by the initiator and its sub-blocks
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_CMD_WIDTH  = DEF_DATA_WIDTH + DEF_ADDR_WIDTH + 1;
    localparam int DEF_NSLV       = 2;
    localparam int DEF_TIMEOUT    = 16;

    // Command word layout {write, addr, wdata} at the default widths
    localparam int WR_BIT   = DEF_CMD_WIDTH - 1;
    localparam int ADDR_LSB = DEF_DATA_WIDTH;

    // Transfer state machine encoding
    typedef logic [1:0] apb_state_t;
    localparam apb_state_t c_st_idle   = 2'd0;
    localparam apb_state_t c_st_setup  = 2'd1;
    localparam apb_state_t c_st_access = 2'd2;
    localparam apb_state_t c_st_resp   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/apb_master_tmo.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_tmo
// Description : ACCESS-phase wait counter. Cleared when a transfer starts,
//               counts enabled cycles and saturates at TIMEOUT, flagging
//               expiry once the limit is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_tmo
    import apb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_at_limit;

    assign w_at_limit = (r_cnt == c_limit);
    assign expired    = w_at_limit;

    // Count ACCESS cycles, holding at the limit so the counter never wraps
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : Single-outstanding APB initiator. Takes a packed command
//               {write, addr, wdata} on a valid/ready port, decodes the slave
//               from the top address bits, runs SETUP/ACCESS with wait-state
//               and timeout handling, and returns data/status on a
//               valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CMD_WIDTH  = DATA_WIDTH + ADDR_WIDTH + 1,
    parameter int NSLV       = DEF_NSLV,
    parameter int SEL_BITS   = $clog2(NSLV),
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [CMD_WIDTH-1:0]       cmd_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic [NSLV-1:0]            psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [ADDR_WIDTH-1:0]      paddr,
    output logic [DATA_WIDTH-1:0]      pwdata,
    input  logic [NSLV*DATA_WIDTH-1:0] prdata,
    input  logic [NSLV-1:0]            pready
);

    localparam int c_wr_bit   = CMD_WIDTH - 1;
    localparam int c_addr_lsb = DATA_WIDTH;

    apb_state_t            r_state;
    logic [SEL_BITS-1:0]   r_idx;

    logic                  w_cmd_write;
    logic [ADDR_WIDTH-1:0] w_cmd_addr;
    logic [DATA_WIDTH-1:0] w_cmd_wdata;
    logic [SEL_BITS-1:0]   w_cmd_idx;
    logic                  w_sel_ready;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                  w_tmo_expired;
    logic [DATA_WIDTH-1:0] w_prdata_arr [NSLV];

    // Command field split and slave decode from the top address bits
    assign w_cmd_write = cmd_data[c_wr_bit];
    assign w_cmd_addr  = cmd_data[c_addr_lsb +: ADDR_WIDTH];
    assign w_cmd_wdata = cmd_data[DATA_WIDTH-1:0];
    assign w_cmd_idx   = w_cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];

    assign cmd_ready   = (r_state == c_st_idle);

    // Per-slave read data view so the selected slice is a plain index
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_rd_slice
        assign w_prdata_arr[gi] = prdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_sel_ready = pready[r_idx];
    assign w_sel_rdata = w_prdata_arr[r_idx];

    // Timeout counter only exists when a non-zero limit is configured
    if (TIMEOUT > 0) begin : g_tmo_on
        apb_master_tmo #(
            .TIMEOUT (TIMEOUT)
        ) u_tmo (
            .clk     (clk),
            .rstn    (rstn),
            .clear   ((r_state == c_st_idle) && cmd_valid),
            .enable  (r_state == c_st_access),
            .expired (w_tmo_expired)
        );
    end else begin : g_tmo_off
        assign w_tmo_expired = 1'b0;
    end

    // Transfer sequencer; every APB and response output is registered here
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= c_st_idle;
            r_idx     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        pwrite  <= w_cmd_write;
                        paddr   <= w_cmd_addr;
                        pwdata  <= w_cmd_wdata;
                        r_idx   <= w_cmd_idx;
                        psel    <= NSLV'(1) << w_cmd_idx;
                        penable <= 1'b0;
                        r_state <= c_st_setup;
                    end
                end
                c_st_setup: begin
                    penable <= 1'b1;
                    r_state <= c_st_access;
                end
                c_st_access: begin
                    // A ready slave wins over a coincident timeout
                    if (w_sel_ready) begin
                        rsp_rdata <= pwrite ? '0 : w_sel_rdata;
                        rsp_err   <= 1'b0;
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_state   <= c_st_resp;
                    end else if (w_tmo_expired) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        psel      <= '0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_state   <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
